control_multiplicador: RTL

//  Moore FSM that sequences the shift-add multiplier datapath built from four

---
 rtl/control_multiplicador.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/control_multiplicador.sv
// control_multiplicador: Moore sequencer for a shift-add multiplier built from
// four universal registers (A accumulator, Q multiplier, M multiplicand,
// P bit counter). Every output is a registered decode of the state being
// entered, so outputs always correspond to the current state.
module control_multiplicador #(
  parameter int ANCHO = 8,
  parameter int PW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          Q0,
  input  logic          P_zero,
  output logic [3:0]    CtrlA,
  output logic [3:0]    CtrlQ,
  output logic [3:0]    CtrlM,
  output logic [3:0]    CtrlP,
  output logic [PW-1:0] CuentaInicial,
  output logic          carry_en,
  output logic          carry_clr,
  output logic          busy,
  output logic          done
);

  // One-hot register control words understood by the universal registers.
  localparam logic [3:0] C_HOLD  = 4'b0000;
  localparam logic [3:0] C_ADD   = 4'b1000;
  localparam logic [3:0] C_SHIFT = 4'b0100;
  localparam logic [3:0] C_DECR  = 4'b0010;
  localparam logic [3:0] C_LOAD  = 4'b0001;

  localparam logic [PW-1:0] CUENTA = PW'(ANCHO);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_TEST  = 3'd2,
    S_ADD   = 3'd3,
    S_SHIFT = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] ctrl_a_q, ctrl_a_d;
  logic [3:0] ctrl_q_q, ctrl_q_d;
  logic [3:0] ctrl_m_q, ctrl_m_d;
  logic [3:0] ctrl_p_q, ctrl_p_d;
  logic       carry_en_q, carry_en_d;
  logic       carry_clr_q, carry_clr_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  // Next-state selection; unknown encodings fall back to IDLE.
  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE:  state_d = start ? S_LOAD : S_IDLE;
      S_LOAD:  state_d = S_TEST;
      S_TEST: begin
        if (P_zero)  state_d = S_DONE;
        else if (Q0) state_d = S_ADD;
        else         state_d = S_SHIFT;
      end
      S_ADD:   state_d = S_SHIFT;
      S_SHIFT: state_d = S_TEST;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode of the state being entered, so the flops hold Moore outputs.
  always_comb begin
    ctrl_a_d    = C_HOLD;
    ctrl_q_d    = C_HOLD;
    ctrl_m_d    = C_HOLD;
    ctrl_p_d    = C_HOLD;
    carry_en_d  = 1'b0;
    carry_clr_d = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    case (state_d)
      S_LOAD: begin
        ctrl_a_d    = C_LOAD;
        ctrl_q_d    = C_LOAD;
        ctrl_m_d    = C_LOAD;
        ctrl_p_d    = C_LOAD;
        carry_clr_d = 1'b1;
        busy_d      = 1'b1;
      end
      S_TEST: begin
        busy_d = 1'b1;
      end
      S_ADD: begin
        ctrl_a_d   = C_ADD;
        carry_en_d = 1'b1;
        busy_d     = 1'b1;
      end
      S_SHIFT: begin
        // A takes the adder carry at its MSB, Q takes A[0]: datapath wiring.
        ctrl_a_d    = C_SHIFT;
        ctrl_q_d    = C_SHIFT;
        ctrl_p_d    = C_DECR;
        carry_clr_d = 1'b1;
        busy_d      = 1'b1;
      end
      S_DONE: begin
        done_d = 1'b1;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset forces IDLE with quiet outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ctrl_a_q    <= C_HOLD;
      ctrl_q_q    <= C_HOLD;
      ctrl_m_q    <= C_HOLD;
      ctrl_p_q    <= C_HOLD;
      carry_en_q  <= 1'b0;
      carry_clr_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ctrl_a_q    <= ctrl_a_d;
      ctrl_q_q    <= ctrl_q_d;
      ctrl_m_q    <= ctrl_m_d;
      ctrl_p_q    <= ctrl_p_d;
      carry_en_q  <= carry_en_d;
      carry_clr_q <= carry_clr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign CtrlA         = ctrl_a_q;
  assign CtrlQ         = ctrl_q_q;
  assign CtrlM         = ctrl_m_q;
  assign CtrlP         = ctrl_p_q;
  assign carry_en      = carry_en_q;
  assign carry_clr     = carry_clr_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign CuentaInicial = CUENTA;

endmodule
